// File: rtl/conv_res_fifo_pkg.sv
// Shared types and defaults for the convolver result FIFO.
package conv_res_fifo_pkg;

  localparam int unsigned RES_WIDTH_DEFAULT = 16;
  localparam int unsigned RES_DEPTH_DEFAULT = 1352;

  typedef logic [RES_WIDTH_DEFAULT-1:0] result_t;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/conv_res_fifo_ptr.sv
// Wrapping FIFO pointer; counts 0..DEPTH-1 and returns to 0, for any DEPTH >= 2.
module conv_res_fifo_ptr
  import conv_res_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = RES_DEPTH_DEFAULT,
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clear,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] r_ptr;

  // Compare-and-clear wrap so non-power-of-two depths need no modulo.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ptr <= '0;
    end else if (clear) begin
      r_ptr <= '0;
    end else if (inc) begin
      if (r_ptr == PW'(DEPTH - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= r_ptr + PW'(1);
      end
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/conv_res_fifo.sv
// Result FIFO between the convolver datapath and the AHB read port.
// Define CONV_RES_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module conv_res_fifo
  import conv_res_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RES_WIDTH_DEFAULT,
  parameter int unsigned DEPTH      = RES_DEPTH_DEFAULT,
  parameter int unsigned AF_THRESH  = DEPTH - 4,
  localparam int unsigned CW        = cnt_width(DEPTH),
  localparam int unsigned PW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  flush,
  input  logic                  wenable,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic                  renable,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         w_waddr;
  logic [PW-1:0]         w_raddr;
  logic                  w_rd;
  logic                  w_wr;

  // Flush swallows both requests; a write into a full FIFO rides on a same-cycle read.
  assign w_rd = renable && !empty && !flush;
  assign w_wr = wenable && (!full || w_rd) && !flush;

  conv_res_fifo_ptr #(
    .DEPTH(DEPTH)
  ) u_wptr (
    .clk  (clk),
    .n_rst(n_rst),
    .clear(flush),
    .inc  (w_wr),
    .ptr  (w_waddr)
  );

  conv_res_fifo_ptr #(
    .DEPTH(DEPTH)
  ) u_rptr (
    .clk  (clk),
    .n_rst(n_rst),
    .clear(flush),
    .inc  (w_rd),
    .ptr  (w_raddr)
  );

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_waddr] <= result_in;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rdata <= '0;
    end else if (w_rd) begin
      r_rdata <= r_mem[w_raddr];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_wr && !w_rd) begin
      r_count <= r_count + CW'(1);
    end else if (w_rd && !w_wr) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign result_out  = r_rdata;
  assign count       = r_count;
  assign empty       = (r_count == '0);
  assign full        = (r_count == CW'(DEPTH));
  assign almost_full = (r_count >= CW'(AF_THRESH));

`ifdef CONV_RES_FIFO_ERR_EN
  logic r_ovf;
  logic r_udf;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (flush) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (wenable && full && !w_rd) begin
        r_ovf <= 1'b1;
      end
      if (renable && empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign overflow  = r_ovf;
  assign underflow = r_udf;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: doc/conv_res_fifo.md
Name: conv_res_fifo

Overview:
- Parametrised second-generation result FIFO for the AHB convolver.
- Buffers convolution results between the datapath (writer) and the AHB slave read port (reader).
- Over the first-generation FIFO, adds:
  - configurable data width and depth (depth need not be a power of two);
  - correct simultaneous read/write accounting;
  - full, almost-full and occupancy outputs;
  - a synchronous flush.

Parameters:
- DATA_WIDTH, 16, width of each stored result in bits.
- DEPTH, 1352, number of entries; any integer >= 2.
- AF_THRESH, DEPTH-4, occupancy at or above which almost_full asserts; legal range 1..DEPTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all FIFO contents.
- wenable  input  1  write request; writes result_in.
- result_in  input  DATA_WIDTH  data to write.
- renable  input  1  read request.
- result_out  output  DATA_WIDTH  registered read data.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- almost_full  output  1  count >= AF_THRESH.
- count  output  CW  current occupancy, where CW = $clog2(DEPTH+1).
- overflow  output  1  sticky write-when-full error (see Optional Feature).
- underflow  output  1  sticky read-when-empty error (see Optional Feature).

Behaviour:
- Reset (n_rst low, asynchronous) and values held while low:
  - waddr, raddr and count are 0; result_out is 0;
  - empty = 1; full = 0; almost_full = 0; overflow = 0; underflow = 0;
  - storage array contents are not reset and are don't-care.
- Pointers waddr and raddr are each $clog2(DEPTH) bits. Each increments by 1 per accepted operation and wraps from DEPTH-1 to 0 (compare-and-clear, no modulo on a non-power-of-2).
- Write is accepted when wenable && (!full || read accepted in the same cycle). On acceptance: mem[waddr] <= result_in and waddr advances.
- Read is accepted when renable && !empty. On acceptance: result_out <= mem[raddr] and raddr advances.
  - Read latency is one cycle: data appears on result_out after the edge that samples renable.
  - result_out holds its last value whenever no read is accepted.
- Simultaneous accepted read and write: count is unchanged.
  - When full, both are accepted: the read takes the oldest entry while the write fills its slot.
  - When empty, only the write is accepted; there is no fall-through.
- Otherwise count is +1 on a write-only cycle and -1 on a read-only cycle. It never exceeds DEPTH and never goes below 0.
- Flush (sampled on the clock edge) has priority over read and write in that cycle:
  - waddr, raddr and count become 0;
  - result_out is unchanged;
  - the error flags clear;
  - any read or write requested in that cycle is ignored.
- Status outputs empty, full and almost_full decode combinationally from the count register, so they are valid in the cycle after the causing edge.
- Reset asserted mid-operation immediately returns all state to the reset values; there is no partial completion.

Optional Feature:
- Macro: CONV_RES_FIFO_ERR_EN.
- Defined:
  - overflow sets when wenable && full && no read is accepted in the same cycle.
  - underflow sets when renable && empty.
  - Both flags are sticky until flush or reset. Rejected operations leave FIFO state untouched.
- Undefined: overflow and underflow are tied to 0 and no flag registers are synthesised.

Decomposition:
- Package conv_res_fifo_pkg holds:
  - RES_WIDTH_DEFAULT = 16 and RES_DEPTH_DEFAULT = 1352;
  - typedef logic [RES_WIDTH_DEFAULT-1:0] result_t;
  - function cnt_width(depth), returning $clog2(depth+1).
- One sub-module, conv_res_fifo_ptr: a parametrised wrapping pointer with inputs clk, n_rst, clear, inc; parameter DEPTH; output ptr. It is instantiated twice, for write and read.

Test Plan (DEPTH=4, DATA_WIDTH=16, AF_THRESH=3 unless noted):
- Reset, then write 0x0001..0x0004 on four consecutive cycles -> count 1,2,3,4; almost_full asserts with count=3; full=1 after the 4th write; empty=0.
- While full, drive wenable with 0x0005 and no read -> count stays 4 and contents are unchanged. With ERR_EN, overflow=1 and remains set.
- While full, read and write 0x0005 in the same cycle -> result_out=0x0001 next cycle; count stays 4. Draining four times then yields 0x0002, 0x0003, 0x0004, 0x0005 (pointer wrap verified).
- While empty, read and write 0x00AA in the same cycle -> result_out unchanged and count=1. Reading next cycle gives 0x00AA and empty=1. With ERR_EN, a read while empty with no write sets underflow.
- With three entries, assert flush together with wenable -> count=0, empty=1, error flags cleared, result_out unchanged. The next write followed by a read returns the new data.
- DEPTH=5 (non-power-of-2): run 12 write/read pairs with incrementing data -> data is returned in order and pointers wrap 4->0. Assert n_rst mid-stream -> all outputs at reset values immediately.
